ctrl_unit: RTL and testbench

- Multi-cycle instruction fetch/decode/execute controller for the 16-bit CPU.
- Sits upstream of the ALU: produces the 3-bit ALU op and register selects that the ALU consumes, and latches the ALU's N/Z/C/P flags into a status register.
- Fetches from instruction memory over a req/ack handshake, drives register-file controls and PC sequencing, and evaluates conditional branches on the latched flags.

---
 rtl/ctrl_unit.sv | 186 ++++++++++++++++++
 tb/tb_ctrl_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit CPU: drives the ALU op,
// register-file selects and PC sequencing. Optional macro ILLEGAL_TRAP_EN halts on illegal opcodes.
module ctrl_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          XLEN     = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_data,
  output logic [3:0]      rf_ra,
  output logic [3:0]      rf_rb,
  output logic [3:0]      rf_wa,
  output logic            rf_we,
  output logic            rf_wsel,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      alu_op,
  input  logic            alu_fN,
  input  logic            alu_fZ,
  input  logic            alu_fC,
  input  logic            alu_fP,
  output logic [3:0]      flags,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_BRC,
    C_LDI,
    C_HLT,
    C_ILL
  } iclass_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;
  logic [3:0]      flags_q;
  logic            halted_q;
  logic            illegal_q;
  logic            rf_we_q;
  logic            rf_wsel_q;
  logic [3:0]      rf_ra_q;
  logic [3:0]      rf_rb_q;
  logic [3:0]      rf_wa_q;
  logic [2:0]      alu_op_q;
  logic [XLEN-1:0] imm_q;

  iclass_e         iclass;
  logic            br_taken;
  logic            enter_halt;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] pc_d;

  // Instruction class and the PC an EXEC of the held IR would produce.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    iclass     = C_ILL;
    br_taken   = 1'b0;
    enter_halt = 1'b0;
    pc_inc     = pc_q + 16'd1;
    br_off     = {{8{ir_q[7]}}, ir_q[7:0]};
    pc_d       = pc_inc;

    if (!ir_q[15]) begin
      iclass = C_ALU;
    end else begin
      case (ir_q[14:12])
        3'b000:  iclass = C_BRC;
        3'b001:  iclass = C_LDI;
        3'b111:  iclass = C_HLT;
        default: iclass = C_ILL;
      endcase
    end

    // An empty mask means "always"; otherwise any selected latched flag takes it.
    br_taken = (ir_q[11:8] == 4'b0000) || ((ir_q[11:8] & flags_q) != 4'b0000);

    case (iclass)
      C_BRC: pc_d = br_taken ? (pc_inc + br_off) : pc_inc;
      C_HLT: begin
        pc_d       = pc_q;
        enter_halt = 1'b1;
      end
      C_ILL: begin
`ifdef ILLEGAL_TRAP_EN
        pc_d       = pc_q;
        enter_halt = 1'b1;
`else
        pc_d       = pc_inc;
`endif
      end
      default: pc_d = pc_inc;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      flags_q   <= 4'b0000;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_wsel_q <= 1'b0;
      rf_ra_q   <= 4'h0;
      rf_rb_q   <= 4'h0;
      rf_wa_q   <= 4'h0;
      alu_op_q  <= 3'b000;
      imm_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;

        // Operand selects are captured with the IR so they are stable from DECODE on.
        S_FETCH: begin
          if (imem_ack) begin
            ir_q     <= imem_data;
            rf_ra_q  <= imem_data[7:4];
            rf_rb_q  <= imem_data[3:0];
            alu_op_q <= imem_data[14:12];
            imm_q    <= {8'h00, imem_data[7:0]};
            state_q  <= S_DECODE;
          end
        end

        // Write controls are set up here so the strobe is high for exactly the EXEC cycle.
        S_DECODE: begin
          rf_we_q   <= (iclass == C_ALU) || (iclass == C_LDI);
          rf_wsel_q <= (iclass == C_LDI);
          rf_wa_q   <= ir_q[11:8];
          state_q   <= S_EXEC;
        end

        S_EXEC: begin
          rf_we_q <= 1'b0;
          pc_q    <= pc_d;
          if (iclass == C_ALU) begin
            flags_q <= {alu_fN, alu_fZ, alu_fC, alu_fP};
          end
          if (iclass == C_ILL) begin
            illegal_q <= 1'b1;
          end
          if (enter_halt) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q  <= S_FETCH;
          end
        end

        S_HALT: state_q <= S_HALT;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = (state_q == S_FETCH);
  // A reset arriving during EXEC must suppress the pending write in that same cycle.
  assign rf_we     = rf_we_q & ~rst;
  assign rf_wsel   = rf_wsel_q;
  assign rf_ra     = rf_ra_q;
  assign rf_rb     = rf_rb_q;
  assign rf_wa     = rf_wa_q;
  assign alu_op    = alu_op_q;
  assign imm       = imm_q;
  assign flags     = flags_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Scoreboard bench for ctrl_unit: the stimulus plays instruction memory and queues expected
// fetches/writes; a negedge monitor pops and compares them as the DUT presents them.
module tb_ctrl_unit;

  typedef struct {
    logic [15:0] addr;
    int          len;   // expected FETCH cycles including the ack cycle, 0 = unchecked
    int          gap;   // cycles since the previous fetch start, 0 = unchecked
  } fetch_t;

  typedef struct {
    logic [3:0]  wa;
    logic        wsel;
    logic [2:0]  op;
    logic [15:0] imm;
    logic [3:0]  ra;
    logic [3:0]  rb;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [3:0]  rf_ra;
  logic [3:0]  rf_rb;
  logic [3:0]  rf_wa;
  logic        rf_we;
  logic        rf_wsel;
  logic [15:0] imm;
  logic [2:0]  alu_op;
  logic        alu_fN;
  logic        alu_fZ;
  logic        alu_fC;
  logic        alu_fP;
  logic [3:0]  flags;
  logic        halted;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  fetch_t fetch_q[$];
  wr_t    write_q[$];

  ctrl_unit #(.RESET_PC(16'h0000), .XLEN(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .rf_ra     (rf_ra),
    .rf_rb     (rf_rb),
    .rf_wa     (rf_wa),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .imm       (imm),
    .alu_op    (alu_op),
    .alu_fN    (alu_fN),
    .alu_fZ    (alu_fZ),
    .alu_fC    (alu_fC),
    .alu_fP    (alu_fP),
    .flags     (flags),
    .halted    (halted),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every fetch start and every register write against the queues.
  fetch_t cur_fetch = '{addr: 16'h0, len: 0, gap: 0};
  logic   prev_req  = 1'b0;
  int     cyc       = 0;
  int     last_start = 0;
  int     run_len   = 0;

  always @(negedge clk) begin
    cyc++;
    if (imem_req === 1'b1 && !prev_req) begin
      if (fetch_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fetch: got addr %0h expected no fetch", imem_addr);
        cur_fetch = '{addr: 16'h0, len: 0, gap: 0};
      end else begin
        cur_fetch = fetch_q.pop_front();
        check("fetch_addr", 32'(imem_addr), 32'(cur_fetch.addr));
        if (cur_fetch.gap != 0) check("fetch_gap", 32'(cyc - last_start), 32'(cur_fetch.gap));
      end
      last_start = cyc;
      run_len    = 0;
    end
    if (imem_req === 1'b1) run_len++;
    if (imem_req === 1'b1 && imem_ack && cur_fetch.len != 0)
      check("fetch_len", 32'(run_len), 32'(cur_fetch.len));
    prev_req = (imem_req === 1'b1);

    if (rf_we === 1'b1) begin
      if (write_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got wa=%0h expected no write", rf_wa);
      end else begin
        wr_t w;
        w = write_q.pop_front();
        check("wr_wa",   32'(rf_wa),   32'(w.wa));
        check("wr_wsel", 32'(rf_wsel), 32'(w.wsel));
        check("wr_op",   32'(alu_op),  32'(w.op));
        check("wr_imm",  32'(imm),     32'(w.imm));
        check("wr_ra",   32'(rf_ra),   32'(w.ra));
        check("wr_rb",   32'(rf_rb),   32'(w.rb));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no imem_req expected one within 50 cycles");
    end
  endtask

  task automatic expect_write(input logic [3:0] wa, input logic wsel, input logic [2:0] op,
                              input logic [15:0] im, input logic [3:0] ra, input logic [3:0] rb);
    wr_t w;
    w = '{wa: wa, wsel: wsel, op: op, imm: im, ra: ra, rb: rb};
    write_q.push_back(w);
  endtask

  // Serves one fetch: expects it at addr, acks after `waits` extra cycles.
  task automatic issue(input logic [15:0] addr, input logic [15:0] instr, input int waits,
                       input int gap);
    fetch_t f;
    f = '{addr: addr, len: waits + 1, gap: gap};
    fetch_q.push_back(f);
    wait_req();
    repeat (waits) tick();
    imem_ack  = 1'b1;
    imem_data = instr;
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
  endtask

  // From DECODE, two edges bring the instruction through EXEC.
  task automatic settle();
    tick();
    tick();
  endtask

  task automatic set_alu(input logic [3:0] f);
    {alu_fN, alu_fZ, alu_fC, alu_fP} = f;
  endtask

  initial begin
    rst       = 1'b1;
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    set_alu(4'b0000);

    // Reset values after two cycles of reset.
    tick();
    tick();
    check("rst_req",     32'(imem_req),  32'h0);
    check("rst_addr",    32'(imem_addr), 32'h0);
    check("rst_we",      32'(rf_we),     32'h0);
    check("rst_halted",  32'(halted),    32'h0);
    check("rst_illegal", 32'(illegal),   32'h0);
    check("rst_flags",   32'(flags),     32'h0);
    check("rst_ra",      32'(rf_ra),     32'h0);
    check("rst_rb",      32'(rf_rb),     32'h0);
    check("rst_wa",      32'(rf_wa),     32'h0);
    check("rst_op",      32'(alu_op),    32'h0);
    check("rst_imm",     32'(imm),       32'h0);
    check("rst_wsel",    32'(rf_wsel),   32'h0);
    rst = 1'b0;
    check("idle_req", 32'(imem_req), 32'h0);

    // SUB r3,r1,r2 with Z from the ALU.
    set_alu(4'b0100);
    expect_write(4'h3, 1'b0, 3'b001, 16'h0012, 4'h1, 4'h2);
    issue(16'h0000, 16'h1312, 0, 0);
    settle();
    check("sub_flags", 32'(flags), 32'h4);

    // LDI r10,0x5C with four wait states; ALU flags must not be latched.
    set_alu(4'b1011);
    expect_write(4'hA, 1'b1, 3'b001, 16'h005C, 4'h5, 4'hC);
    issue(16'h0001, 16'h9A5C, 4, 3);
    settle();
    check("ldi_flags", 32'(flags), 32'h4);

    // Branch chain: to 0010, Z-taken back to 000F, always to 0010, N not taken,
    // then backward wrap to FF92, forward to FFFF, and wrap to 0001.
    issue(16'h0002, 16'h840D, 0, 7);
    issue(16'h0010, 16'h84FE, 0, 3);
    issue(16'h000F, 16'h8000, 0, 3);
    issue(16'h0010, 16'h88FE, 0, 3);
    issue(16'h0011, 16'h8080, 0, 3);
    issue(16'hFF92, 16'h806C, 0, 3);
    issue(16'hFFFF, 16'h8001, 0, 3);

    // Illegal opcode.
    issue(16'h0001, 16'hB000, 0, 3);
    settle();
    check("ill_flag", 32'(illegal), 32'h1);
`ifdef ILLEGAL_TRAP_EN
    check("ill_halted", 32'(halted),    32'h1);
    check("ill_pc",     32'(imem_addr), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("trap_req", 32'(imem_req), 32'h0);
    end
`else
    check("ill_halted", 32'(halted), 32'h0);

    // ADD r4,r5,r6 latching N and C, then a C-masked branch that is taken.
    set_alu(4'b1010);
    expect_write(4'h4, 1'b0, 3'b000, 16'h0056, 4'h5, 4'h6);
    issue(16'h0002, 16'h0456, 0, 3);
    settle();
    check("add_flags", 32'(flags), 32'hA);
    issue(16'h0003, 16'h8205, 0, 3);

    // HLT: no further fetches and the PC stays put.
    issue(16'h0009, 16'hF000, 0, 3);
    settle();
    check("hlt_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hlt_req", 32'(imem_req), 32'h0);
    end
    check("hlt_pc",      32'(imem_addr), 32'h9);
    check("hlt_illegal", 32'(illegal),   32'h1);
`endif

    // Reset out of HALT clears status.
    rst = 1'b1;
    tick();
    check("rst2_halted",  32'(halted),    32'h0);
    check("rst2_illegal", 32'(illegal),   32'h0);
    check("rst2_flags",   32'(flags),     32'h0);
    check("rst2_addr",    32'(imem_addr), 32'h0);
    rst = 1'b0;

    // Reset lands on the same edge as an ack: the fetched LDI must never retire.
    begin
      fetch_t f;
      f = '{addr: 16'h0000, len: 0, gap: 0};
      fetch_q.push_back(f);
    end
    wait_req();
    imem_ack  = 1'b1;
    imem_data = 16'h9111;
    rst       = 1'b1;
    tick();
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
    rst       = 1'b0;
    check("abort_req", 32'(imem_req), 32'h0);
    check("abort_we",  32'(rf_we),    32'h0);

    issue(16'h0000, 16'hF000, 0, 2);
    settle();
    check("end_halted", 32'(halted), 32'h1);
    repeat (5) tick();

    check("fetch_q_drained", 32'(fetch_q.size()), 32'h0);
    check("write_q_drained", 32'(write_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
